// File: rtl/zynq_axi4_to_axi3_splitter.sv
// Splits AXI4 INCR bursts from the BlackParrot memory master into
// AXI3 sub-bursts of at most 16 beats for the Zynq PS HP port.
`timescale 1ns/1ps
module zynq_axi4_to_axi3_splitter #(
    parameter int C_M00_AXI_ADDR_WIDTH = 32,
    parameter int C_M00_AXI_DATA_WIDTH = 64,
    parameter int C_ID_WIDTH = 6
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0] s_axi_awlen,
    input  logic [2:0] s_axi_awsize,
    input  logic [1:0] s_axi_awburst,
    input  logic [C_ID_WIDTH-1:0] s_axi_awid,
    input  logic s_axi_awvalid,
    output logic s_axi_awready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic s_axi_wlast,
    input  logic s_axi_wvalid,
    output logic s_axi_wready,
    output logic [C_ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0] s_axi_bresp,
    output logic s_axi_bvalid,
    input  logic s_axi_bready,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0] s_axi_arlen,
    input  logic [2:0] s_axi_arsize,
    input  logic [1:0] s_axi_arburst,
    input  logic [C_ID_WIDTH-1:0] s_axi_arid,
    input  logic s_axi_arvalid,
    output logic s_axi_arready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [C_ID_WIDTH-1:0] s_axi_rid,
    output logic [1:0] s_axi_rresp,
    output logic s_axi_rlast,
    output logic s_axi_rvalid,
    input  logic s_axi_rready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_awaddr,
    output logic [3:0] m00_axi_awlen,
    output logic [2:0] m00_axi_awsize,
    output logic [1:0] m00_axi_awburst,
    output logic [C_ID_WIDTH-1:0] m00_axi_awid,
    output logic [1:0] m00_axi_awlock,
    output logic [3:0] m00_axi_awcache,
    output logic [2:0] m00_axi_awprot,
    output logic [3:0] m00_axi_awqos,
    output logic m00_axi_awvalid,
    input  logic m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic [C_ID_WIDTH-1:0] m00_axi_wid,
    output logic m00_axi_wlast,
    output logic m00_axi_wvalid,
    input  logic m00_axi_wready,
    input  logic [C_ID_WIDTH-1:0] m00_axi_bid,
    input  logic [1:0] m00_axi_bresp,
    input  logic m00_axi_bvalid,
    output logic m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [3:0] m00_axi_arlen,
    output logic [2:0] m00_axi_arsize,
    output logic [1:0] m00_axi_arburst,
    output logic [C_ID_WIDTH-1:0] m00_axi_arid,
    output logic [1:0] m00_axi_arlock,
    output logic [3:0] m00_axi_arcache,
    output logic [2:0] m00_axi_arprot,
    output logic [3:0] m00_axi_arqos,
    output logic m00_axi_arvalid,
    input  logic m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [C_ID_WIDTH-1:0] m00_axi_rid,
    input  logic [1:0] m00_axi_rresp,
    input  logic m00_axi_rlast,
    input  logic m00_axi_rvalid,
    output logic m00_axi_rready
);
    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int IW = C_ID_WIDTH;

    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_BRSP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t w_state;
    logic [AW-1:0] w_addr, w_step;
    logic [2:0] w_size;
    logic [IW-1:0] w_id;
    logic [8:0] w_rem;
    logic [3:0] w_beat, w_sub;
    logic [1:0] resp_acc;
    logic w_hs, w_last;

    r_state_t r_state;
    logic [AW-1:0] r_addr, r_step;
    logic [2:0] r_size;
    logic [IW-1:0] r_id;
    logic [8:0] r_rem;
    logic [3:0] r_sub;
    logic r_final, r_end;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awburst, s_axi_arburst, s_axi_wlast,
                             m00_axi_bid, m00_axi_rid};

    assign w_sub  = (w_rem > 9'd16) ? 4'hf : 4'(w_rem - 9'd1);
    assign w_step = AW'(5'(w_sub) + 5'd1) << w_size;
    assign w_hs   = (w_state == W_DATA) && s_axi_wvalid && m00_axi_wready;
    assign w_last = (w_beat == w_sub);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state  <= W_IDLE;
            w_addr   <= '0;
            w_size   <= '0;
            w_id     <= '0;
            w_rem    <= '0;
            w_beat   <= '0;
            resp_acc <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: if (s_axi_awvalid) begin
                    w_addr  <= s_axi_awaddr;
                    w_size  <= s_axi_awsize;
                    w_id    <= s_axi_awid;
                    w_rem   <= {1'b0, s_axi_awlen} + 9'd1;
                    w_state <= W_ADDR;
                end
                W_ADDR: if (m00_axi_awready) begin
                    w_beat  <= '0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    w_beat <= w_beat + 4'd1;
                    if (w_last) w_state <= W_RESP;
                end
                W_RESP: if (m00_axi_bvalid) begin
                    // Worst sub-burst response wins: DECERR > SLVERR > OKAY
                    if (m00_axi_bresp > resp_acc) resp_acc <= m00_axi_bresp;
                    w_rem <= w_rem - (9'(w_sub) + 9'd1);
                    if (w_rem == 9'(w_sub) + 9'd1) begin
                        w_state <= W_BRSP;
                    end else begin
                        w_addr  <= w_addr + w_step;
                        w_state <= W_ADDR;
                    end
                end
                W_BRSP: if (s_axi_bready) begin
                    resp_acc <= '0;
                    w_state  <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign s_axi_awready   = aresetn && (w_state == W_IDLE);
    assign m00_axi_awvalid = (w_state == W_ADDR);
    assign m00_axi_awaddr  = w_addr;
    assign m00_axi_awlen   = w_sub;
    assign m00_axi_awsize  = w_size;
    assign m00_axi_awburst = 2'b01;
    assign m00_axi_awid    = w_id;
    assign m00_axi_awlock  = 2'b00;
    assign m00_axi_awcache = 4'b0011;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awqos   = 4'b0000;
    assign m00_axi_wvalid  = (w_state == W_DATA) && s_axi_wvalid;
    assign s_axi_wready    = (w_state == W_DATA) && m00_axi_wready;
    assign m00_axi_wlast   = (w_state == W_DATA) && w_last;
    assign m00_axi_wdata   = s_axi_wdata;
    assign m00_axi_wstrb   = s_axi_wstrb;
    assign m00_axi_wid     = w_id;
    assign m00_axi_bready  = (w_state == W_RESP);
    assign s_axi_bvalid    = (w_state == W_BRSP);
    assign s_axi_bresp     = resp_acc;
    assign s_axi_bid       = w_id;

    assign r_sub   = (r_rem > 9'd16) ? 4'hf : 4'(r_rem - 9'd1);
    assign r_step  = AW'(5'(r_sub) + 5'd1) << r_size;
    assign r_final = (r_rem <= 9'd16);
    assign r_end   = m00_axi_rvalid && s_axi_rready && m00_axi_rlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_size  <= '0;
            r_id    <= '0;
            r_rem   <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: if (s_axi_arvalid) begin
                    r_addr  <= s_axi_araddr;
                    r_size  <= s_axi_arsize;
                    r_id    <= s_axi_arid;
                    r_rem   <= {1'b0, s_axi_arlen} + 9'd1;
                    r_state <= R_ADDR;
                end
                R_ADDR: if (m00_axi_arready) r_state <= R_DATA;
                R_DATA: if (r_end) begin
                    r_rem <= r_rem - (9'(r_sub) + 9'd1);
                    if (r_final) begin
                        r_state <= R_IDLE;
                    end else begin
                        r_addr  <= r_addr + r_step;
                        r_state <= R_ADDR;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s_axi_arready   = aresetn && (r_state == R_IDLE);
    assign m00_axi_arvalid = (r_state == R_ADDR);
    assign m00_axi_araddr  = r_addr;
    assign m00_axi_arlen   = r_sub;
    assign m00_axi_arsize  = r_size;
    assign m00_axi_arburst = 2'b01;
    assign m00_axi_arid    = r_id;
    assign m00_axi_arlock  = 2'b00;
    assign m00_axi_arcache = 4'b0011;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arqos   = 4'b0000;
    assign s_axi_rvalid    = (r_state == R_DATA) && m00_axi_rvalid;
    assign m00_axi_rready  = (r_state == R_DATA) && s_axi_rready;
    assign s_axi_rlast     = s_axi_rvalid && m00_axi_rlast && r_final;
    assign s_axi_rdata     = m00_axi_rdata;
    assign s_axi_rresp     = m00_axi_rresp;
    assign s_axi_rid       = r_id;

endmodule

// File: tb/tb_zynq_axi4_to_axi3_splitter.sv
// Directed bench for the AXI4-to-AXI3 burst splitter, with a
// behavioural PS HP slave on the AXI3 side.
`timescale 1ns/1ps
module tb_zynq_axi4_to_axi3_splitter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 6;
    localparam int LIM = 20000;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0] s_axi_awlen, s_axi_arlen;
    logic [2:0] s_axi_awsize, s_axi_arsize;
    logic [1:0] s_axi_awburst, s_axi_arburst;
    logic [IW-1:0] s_axi_awid, s_axi_arid;
    logic s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
    logic [DW-1:0] s_axi_wdata, s_axi_rdata;
    logic [DW/8-1:0] s_axi_wstrb;
    logic s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [IW-1:0] s_axi_bid, s_axi_rid;
    logic [1:0] s_axi_bresp, s_axi_rresp;
    logic s_axi_bvalid, s_axi_bready;
    logic s_axi_rlast, s_axi_rvalid, s_axi_rready;

    logic [AW-1:0] m00_axi_awaddr, m00_axi_araddr;
    logic [3:0] m00_axi_awlen, m00_axi_arlen;
    logic [2:0] m00_axi_awsize, m00_axi_arsize;
    logic [1:0] m00_axi_awburst, m00_axi_arburst;
    logic [IW-1:0] m00_axi_awid, m00_axi_arid;
    logic [1:0] m00_axi_awlock, m00_axi_arlock;
    logic [3:0] m00_axi_awcache, m00_axi_arcache;
    logic [2:0] m00_axi_awprot, m00_axi_arprot;
    logic [3:0] m00_axi_awqos, m00_axi_arqos;
    logic m00_axi_awvalid, m00_axi_awready;
    logic m00_axi_arvalid, m00_axi_arready;
    logic [DW-1:0] m00_axi_wdata, m00_axi_rdata;
    logic [DW/8-1:0] m00_axi_wstrb;
    logic [IW-1:0] m00_axi_wid, m00_axi_bid, m00_axi_rid;
    logic m00_axi_wlast, m00_axi_wvalid, m00_axi_wready;
    logic [1:0] m00_axi_bresp, m00_axi_rresp;
    logic m00_axi_bvalid, m00_axi_bready;
    logic m00_axi_rlast, m00_axi_rvalid, m00_axi_rready;

    zynq_axi4_to_axi3_splitter dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awid(s_axi_awid), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arid(s_axi_arid), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awlen(m00_axi_awlen),
        .m00_axi_awsize(m00_axi_awsize), .m00_axi_awburst(m00_axi_awburst),
        .m00_axi_awid(m00_axi_awid), .m00_axi_awlock(m00_axi_awlock),
        .m00_axi_awcache(m00_axi_awcache), .m00_axi_awprot(m00_axi_awprot),
        .m00_axi_awqos(m00_axi_awqos), .m00_axi_awvalid(m00_axi_awvalid),
        .m00_axi_awready(m00_axi_awready),
        .m00_axi_wdata(m00_axi_wdata), .m00_axi_wstrb(m00_axi_wstrb),
        .m00_axi_wid(m00_axi_wid), .m00_axi_wlast(m00_axi_wlast),
        .m00_axi_wvalid(m00_axi_wvalid), .m00_axi_wready(m00_axi_wready),
        .m00_axi_bid(m00_axi_bid), .m00_axi_bresp(m00_axi_bresp),
        .m00_axi_bvalid(m00_axi_bvalid), .m00_axi_bready(m00_axi_bready),
        .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen),
        .m00_axi_arsize(m00_axi_arsize), .m00_axi_arburst(m00_axi_arburst),
        .m00_axi_arid(m00_axi_arid), .m00_axi_arlock(m00_axi_arlock),
        .m00_axi_arcache(m00_axi_arcache), .m00_axi_arprot(m00_axi_arprot),
        .m00_axi_arqos(m00_axi_arqos), .m00_axi_arvalid(m00_axi_arvalid),
        .m00_axi_arready(m00_axi_arready),
        .m00_axi_rdata(m00_axi_rdata), .m00_axi_rid(m00_axi_rid),
        .m00_axi_rresp(m00_axi_rresp), .m00_axi_rlast(m00_axi_rlast),
        .m00_axi_rvalid(m00_axi_rvalid), .m00_axi_rready(m00_axi_rready)
    );

    int checks = 0;
    int errors = 0;
    bit rnd = 1'b0;
    int b_cnt = 0;
    logic [IW-1:0] exp_wid = '0;
    logic [IW-1:0] exp_rid = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit coin();
        return rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    function automatic logic [63:0] wpat(input logic [31:0] a, input int i);
        return {a ^ 32'hA5A5_0000, 32'(i)};
    endfunction

    function automatic logic [63:0] rpat(input logic [31:0] a);
        return {~a, a};
    endfunction

    // AXI3 slave model: write side
    logic [31:0] aw_log_addr[$], wa_log[$];
    logic [3:0] aw_log_len[$];
    logic [63:0] wd_log[$];
    int wlast_pos[$];
    logic [1:0] bresp_q[$];
    logic [31:0] sw_addr;
    logic [3:0] sw_len;
    int sw_beat = 0, sw_total = 0;
    bit sb_pend = 1'b0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m00_axi_awready <= 1'b0;
            m00_axi_wready  <= 1'b0;
            m00_axi_bvalid  <= 1'b0;
            m00_axi_bresp   <= 2'b00;
            m00_axi_bid     <= '0;
            sw_beat = 0;
            sb_pend = 1'b0;
        end else begin
            if (m00_axi_awvalid && m00_axi_awready) begin
                aw_log_addr.push_back(m00_axi_awaddr);
                aw_log_len.push_back(m00_axi_awlen);
                chk("awid", 64'(m00_axi_awid), 64'(exp_wid));
                chk("aw_fixed", 64'({m00_axi_awsize, m00_axi_awburst,
                    m00_axi_awlock, m00_axi_awcache, m00_axi_awprot,
                    m00_axi_awqos}), 64'({3'd3, 2'b01, 2'b00, 4'b0011,
                    3'b000, 4'b0000}));
                sw_addr = m00_axi_awaddr;
                sw_len  = m00_axi_awlen;
                sw_beat = 0;
            end
            if (m00_axi_wvalid && m00_axi_wready) begin
                wd_log.push_back(m00_axi_wdata);
                wa_log.push_back(sw_addr + 32'(sw_beat) * 32'd8);
                sw_total++;
                chk("wlast", 64'(m00_axi_wlast), 64'(sw_beat == int'(sw_len)));
                chk("wid", 64'(m00_axi_wid), 64'(exp_wid));
                chk("wstrb", 64'(m00_axi_wstrb), 64'hff);
                if (m00_axi_wlast) wlast_pos.push_back(sw_total);
                if (sw_beat == int'(sw_len)) sb_pend = 1'b1;
                sw_beat++;
            end
            if (m00_axi_bvalid && m00_axi_bready) begin
                m00_axi_bvalid <= 1'b0;
            end else if (sb_pend && !m00_axi_bvalid && coin()) begin
                m00_axi_bvalid <= 1'b1;
                m00_axi_bid    <= exp_wid;
                m00_axi_bresp  <= (bresp_q.size() > 0) ?
                                  bresp_q.pop_front() : 2'b00;
                sb_pend = 1'b0;
            end
            m00_axi_awready <= coin();
            m00_axi_wready  <= coin();
        end
    end

    // AXI3 slave model: read side, data derived from the beat address
    logic [31:0] ar_log_addr[$], rq_addr[$];
    logic [3:0] ar_log_len[$], rq_len[$];
    bit sr_act = 1'b0;
    logic [31:0] sr_addr;
    logic [3:0] sr_len;
    int sr_beat = 0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m00_axi_arready <= 1'b0;
            m00_axi_rvalid  <= 1'b0;
            m00_axi_rlast   <= 1'b0;
            m00_axi_rdata   <= '0;
            m00_axi_rid     <= '0;
            m00_axi_rresp   <= 2'b00;
            sr_act = 1'b0;
            rq_addr.delete();
            rq_len.delete();
        end else begin
            if (m00_axi_arvalid && m00_axi_arready) begin
                ar_log_addr.push_back(m00_axi_araddr);
                ar_log_len.push_back(m00_axi_arlen);
                rq_addr.push_back(m00_axi_araddr);
                rq_len.push_back(m00_axi_arlen);
                chk("arid", 64'(m00_axi_arid), 64'(exp_rid));
                chk("ar_fixed", 64'({m00_axi_arsize, m00_axi_arburst,
                    m00_axi_arlock, m00_axi_arcache, m00_axi_arprot,
                    m00_axi_arqos}), 64'({3'd3, 2'b01, 2'b00, 4'b0011,
                    3'b000, 4'b0000}));
            end
            if (m00_axi_rvalid && m00_axi_rready) begin
                if (sr_beat == int'(sr_len)) sr_act = 1'b0;
                else sr_beat++;
            end
            if (!sr_act && rq_addr.size() > 0) begin
                sr_addr = rq_addr.pop_front();
                sr_len  = rq_len.pop_front();
                sr_beat = 0;
                sr_act  = 1'b1;
            end
            if (!(m00_axi_rvalid && !m00_axi_rready)) begin
                if (sr_act && coin()) begin
                    m00_axi_rvalid <= 1'b1;
                    m00_axi_rdata  <= rpat(sr_addr + 32'(sr_beat) * 32'd8);
                    m00_axi_rlast  <= (sr_beat == int'(sr_len));
                    m00_axi_rid    <= exp_rid;
                    m00_axi_rresp  <= 2'b00;
                end else begin
                    m00_axi_rvalid <= 1'b0;
                    m00_axi_rlast  <= 1'b0;
                end
            end
            m00_axi_arready <= coin();
        end
    end

    always @(posedge aclk)
        if (aresetn && s_axi_bvalid && s_axi_bready) b_cnt++;

    task automatic send_aw(input logic [31:0] a, input logic [7:0] l,
                           input logic [IW-1:0] id);
        int t = 0;
        @(negedge aclk);
        s_axi_awaddr = a; s_axi_awlen = l; s_axi_awsize = 3'd3;
        s_axi_awburst = 2'b01; s_axi_awid = id; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && t < LIM) begin
            @(negedge aclk);
            t++;
        end
        chk("aw_accept_timeout", 64'(t >= LIM), 64'd0);
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        chk("awvalid_latency", 64'(m00_axi_awvalid), 64'd1);
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                           input logic [IW-1:0] id);
        int t = 0;
        @(negedge aclk);
        s_axi_araddr = a; s_axi_arlen = l; s_axi_arsize = 3'd3;
        s_axi_arburst = 2'b01; s_axi_arid = id; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && t < LIM) begin
            @(negedge aclk);
            t++;
        end
        chk("ar_accept_timeout", 64'(t >= LIM), 64'd0);
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        chk("arvalid_latency", 64'(m00_axi_arvalid), 64'd1);
    endtask

    task automatic wr_data(input int n, input int len, input logic [31:0] a);
        int i = 0, t = 0;
        bit held = 1'b0;
        while (i < n && t < LIM) begin
            @(negedge aclk);
            t++;
            if (!held) begin
                s_axi_wvalid = coin();
                s_axi_wdata  = wpat(a, i);
                s_axi_wstrb  = '1;
                s_axi_wlast  = (i == len);
            end
            held = s_axi_wvalid && !s_axi_wready;
            if (s_axi_wvalid && s_axi_wready) i++;
        end
        chk("w_timeout", 64'(i < n), 64'd0);
    endtask

    task automatic recv_b(output logic [1:0] resp, output logic [IW-1:0] id);
        int t = 0;
        bit got = 1'b0;
        while (!got && t < LIM) begin
            @(negedge aclk);
            t++;
            s_axi_bready = coin();
            got = s_axi_bvalid && s_axi_bready;
        end
        resp = s_axi_bresp;
        id = s_axi_bid;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        chk("b_received", 64'(got), 64'd1);
    endtask

    task automatic rd_data(input int n, input logic [31:0] a,
                           input logic [IW-1:0] id);
        int i = 0, t = 0;
        while (i < n && t < LIM) begin
            @(negedge aclk);
            t++;
            s_axi_rready = coin();
            if (s_axi_rvalid && s_axi_rready) begin
                chk("rdata", s_axi_rdata, rpat(a + 32'(i) * 32'd8));
                chk("rlast", 64'(s_axi_rlast), 64'(i == n - 1));
                chk("rid", 64'(s_axi_rid), 64'(id));
                chk("rresp", 64'(s_axi_rresp), 64'd0);
                i++;
            end
        end
        chk("r_timeout", 64'(i < n), 64'd0);
    endtask

    task automatic wr_burst(input logic [31:0] a, input int l,
                            input logic [IW-1:0] id, input logic [1:0] er);
        logic [1:0] r;
        logic [IW-1:0] bid;
        int subs;
        subs = (l + 16) / 16;
        exp_wid = id;
        aw_log_addr.delete(); aw_log_len.delete();
        wd_log.delete(); wa_log.delete(); wlast_pos.delete();
        sw_total = 0;
        b_cnt = 0;
        fork
            send_aw(a, 8'(l), id);
            begin
                wr_data(l + 1, l, a);
                @(negedge aclk);
                s_axi_wvalid = 1'b0;
                s_axi_wlast = 1'b0;
            end
            recv_b(r, bid);
        join
        chk("bresp", 64'(r), 64'(er));
        chk("bid", 64'(bid), 64'(id));
        chk("aw_count", 64'(aw_log_addr.size()), 64'(subs));
        for (int k = 0; k < aw_log_addr.size() && k < subs; k++) begin
            chk("aw_addr", 64'(aw_log_addr[k]), 64'(a + 32'(k) * 32'd128));
            chk("aw_len", 64'(aw_log_len[k]),
                64'((k == subs - 1) ? (l % 16) : 15));
        end
        chk("w_count", 64'(wd_log.size()), 64'(l + 1));
        for (int i = 0; i < wd_log.size() && i <= l; i++) begin
            chk("w_data", wd_log[i], wpat(a, i));
            chk("w_addr", 64'(wa_log[i]), 64'(a + 32'(i) * 32'd8));
        end
        chk("wlast_count", 64'(wlast_pos.size()), 64'(subs));
        for (int k = 0; k < wlast_pos.size() && k < subs; k++)
            chk("wlast_beat", 64'(wlast_pos[k]),
                64'((16 * (k + 1) < l + 1) ? 16 * (k + 1) : l + 1));
        repeat (4) @(negedge aclk);
        chk("b_count", 64'(b_cnt), 64'd1);
        chk("bvalid_idle", 64'(s_axi_bvalid), 64'd0);
    endtask

    task automatic rd_burst(input logic [31:0] a, input int l,
                            input logic [IW-1:0] id);
        int subs;
        subs = (l + 16) / 16;
        exp_rid = id;
        ar_log_addr.delete(); ar_log_len.delete();
        fork
            send_ar(a, 8'(l), id);
            begin
                rd_data(l + 1, a, id);
                @(negedge aclk);
                s_axi_rready = 1'b0;
            end
        join
        chk("ar_count", 64'(ar_log_addr.size()), 64'(subs));
        for (int k = 0; k < ar_log_addr.size() && k < subs; k++) begin
            chk("ar_addr", 64'(ar_log_addr[k]), 64'(a + 32'(k) * 32'd128));
            chk("ar_len", 64'(ar_log_len[k]),
                64'((k == subs - 1) ? (l % 16) : 15));
        end
    endtask

    function automatic logic [12:0] hs_outs();
        return {m00_axi_awvalid, m00_axi_wvalid, m00_axi_wlast,
                m00_axi_bready, m00_axi_arvalid, m00_axi_rready,
                s_axi_awready, s_axi_wready, s_axi_bvalid,
                s_axi_arready, s_axi_rvalid, s_axi_rlast,
                |s_axi_bresp};
    endfunction

    initial begin
        s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awid = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arid = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        #1 aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        chk("reset_outputs", 64'(hs_outs()), 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("idle_awready", 64'(s_axi_awready), 64'd1);
        chk("idle_arready", 64'(s_axi_arready), 64'd1);

        wr_burst(32'h8000_0000, 0, 6'h11, 2'b00);
        wr_burst(32'h8000_1000, 63, 6'h22, 2'b00);
        rd_burst(32'h8000_2000, 19, 6'h33);

        bresp_q.push_back(2'b00);
        bresp_q.push_back(2'b10);
        wr_burst(32'h8000_3000, 31, 6'h04, 2'b10);
        wr_burst(32'h8000_3400, 0, 6'h05, 2'b00);

        rnd = 1'b1;
        fork
            wr_burst(32'h8001_0000, 255, 6'h3a, 2'b00);
            rd_burst(32'h8002_0000, 255, 6'h15);
        join
        rnd = 1'b0;

        exp_wid = 6'h2b;
        send_aw(32'h8000_5000, 8'd15, 6'h2b);
        wr_data(6, 15, 32'h8000_5000);
        @(negedge aclk);
        s_axi_wdata = wpat(32'h8000_5000, 6);
        s_axi_wvalid = 1'b1;
        s_axi_wlast = 1'b0;
        #1;
        chk("beat7_wvalid", 64'(m00_axi_wvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("abort_outputs", 64'(hs_outs()), 64'd0);
        repeat (2) @(negedge aclk);
        s_axi_wvalid = 1'b0;
        aresetn = 1'b1;

        wr_burst(32'h8000_4000, 0, 6'h2c, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
